bus_xfer_ctrl: RTL and testbench



---
 rtl/bus_codes_pkg.sv | 50 +++++
 rtl/bus_xfer_ctrl_if.sv | 27 ++
 rtl/bus_xfer_ctrl_fifo.sv | 59 +++++
 rtl/bus_xfer_ctrl.sv | 103 ++++++++++
 tb/tb_bus_xfer_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_codes_pkg.sv
// Shared bus code definitions for the 32-bit internal CPU bus.
// Holds source/destination codes used by the bus mux, the control unit and
// the transfer sequencer, plus the sequencer FSM state type.
package bus_codes_pkg;

   localparam int SRC_W      = 6;
   localparam int DST_W      = 5;
   localparam int XFER_W     = SRC_W + DST_W;
   localparam int DST_LOAD_W = 24;

   localparam logic [SRC_W-1:0] SRC_R0      = 6'd0;
   localparam logic [SRC_W-1:0] SRC_R15     = 6'd15;
   localparam logic [SRC_W-1:0] SRC_HI      = 6'd16;
   localparam logic [SRC_W-1:0] SRC_LO      = 6'd17;
   localparam logic [SRC_W-1:0] SRC_ZHI     = 6'd18;
   localparam logic [SRC_W-1:0] SRC_ZLO     = 6'd19;
   localparam logic [SRC_W-1:0] SRC_PC      = 6'd20;
   localparam logic [SRC_W-1:0] SRC_MDR     = 6'd21;
   localparam logic [SRC_W-1:0] SRC_INPORT  = 6'd22;
   localparam logic [SRC_W-1:0] SRC_CSIGNEX = 6'd23;
   localparam logic [SRC_W-1:0] SRC_MAX     = SRC_CSIGNEX;

   localparam logic [DST_W-1:0] DST_R0      = 5'd0;
   localparam logic [DST_W-1:0] DST_R15     = 5'd15;
   localparam logic [DST_W-1:0] DST_HI      = 5'd16;
   localparam logic [DST_W-1:0] DST_LO      = 5'd17;
   localparam logic [DST_W-1:0] DST_PC      = 5'd18;
   localparam logic [DST_W-1:0] DST_MDR     = 5'd19;
   localparam logic [DST_W-1:0] DST_MAR     = 5'd20;
   localparam logic [DST_W-1:0] DST_Y       = 5'd21;
   localparam logic [DST_W-1:0] DST_IR      = 5'd22;
   localparam logic [DST_W-1:0] DST_OUTPORT = 5'd23;
   localparam logic [DST_W-1:0] DST_MAX     = DST_OUTPORT;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_DRIVE,
      XF_WAIT
   } xfer_state_e;

   function automatic logic codes_legal(input logic [SRC_W-1:0] src,
                                        input logic [DST_W-1:0] dst);
      return (src <= SRC_MAX) && (dst <= DST_MAX);
   endfunction

   function automatic logic [DST_LOAD_W-1:0] dst_onehot(input logic [DST_W-1:0] dst);
      return DST_LOAD_W'(1) << dst;
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request/bus-drive bundle between the control unit (master) and the
// transfer sequencer (slave).
//   req_valid/req_ready/req_src/req_dst : transfer request handshake
//   mdr_valid                           : memory data present in MDR
//   Select/dst_load                     : bus mux select, one-hot load enable
//   busy/err                            : status
interface bus_xfer_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_src;
   logic [4:0]  req_dst;
   logic        mdr_valid;
   logic [5:0]  Select;
   logic [23:0] dst_load;
   logic        busy;
   logic        err;

   modport master (
      output req_valid, req_src, req_dst, mdr_valid,
      input  req_ready, Select, dst_load, busy, err
   );

   modport slave (
      input  req_valid, req_src, req_dst, mdr_valid,
      output req_ready, Select, dst_load, busy, err
   );
endinterface

// File: rtl/bus_xfer_ctrl_fifo.sv
// xfer_fifo: synchronous request FIFO with asynchronous clear.
//   clk_i, rst_i       : clock, async active-high clear (empties the FIFO)
//   push_i/data_i      : write side, ignored when full
//   pop_i/data_o       : read side, data_o shows the head, pop ignored when empty
//   full_o/empty_o     : flags derived from the registered occupancy count
module xfer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: queues register-transfer requests and drives the bus mux
// source select plus a one-hot destination load enable.
//   clock, clear : clock and async active-high reset
//   bus (slave)  : request handshake, mdr_valid, Select, dst_load, busy, err
//
// state    | meaning
// ---------+-----------------------------------------------------------
// XF_IDLE  | nothing driven; pops the FIFO head when one is available
// XF_DRIVE | Select/dst_load valid for one cycle; may pop the next entry
// XF_WAIT  | MDR-source transfer holding Select=MDR until mdr_valid
module bus_xfer_ctrl
   import bus_codes_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [SRC_W-1:0] IDLE_SEL = 6'd0
) (
   input logic            clock,
   input logic            clear,
   bus_xfer_ctrl_if.slave bus
);

   xfer_state_e           state_q;
   logic [SRC_W-1:0]      select_q;
   logic [DST_LOAD_W-1:0] load_q;
   logic [DST_W-1:0]      wait_dst_q;
   logic                  err_q;

   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [XFER_W-1:0]     fifo_rdata;
   logic [SRC_W-1:0]      head_src;
   logic [DST_W-1:0]      head_dst;

   assign fifo_push = bus.req_valid && !fifo_full;
   // The head is consumed whenever the FSM is not parked on an MDR wait.
   assign fifo_pop  = !fifo_empty && (state_q != XF_WAIT);
   assign head_src  = fifo_rdata[XFER_W-1:DST_W];
   assign head_dst  = fifo_rdata[DST_W-1:0];

   xfer_fifo #(.DEPTH(DEPTH), .WIDTH(XFER_W)) u_fifo (
      .clk_i   (clock),
      .rst_i   (clear),
      .push_i  (fifo_push),
      .data_i  ({bus.req_src, bus.req_dst}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q    <= XF_IDLE;
         select_q   <= IDLE_SEL;
         load_q     <= '0;
         wait_dst_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            XF_IDLE, XF_DRIVE: begin
               if (fifo_empty) begin
                  state_q  <= XF_IDLE;
                  select_q <= IDLE_SEL;
                  load_q   <= '0;
               end else if (!codes_legal(head_src, head_dst)) begin
                  // Illegal entry is dropped in its pop cycle with no load.
                  state_q  <= XF_IDLE;
                  select_q <= IDLE_SEL;
                  load_q   <= '0;
                  err_q    <= 1'b1;
               end else if (head_src == SRC_MDR && !bus.mdr_valid) begin
                  state_q    <= XF_WAIT;
                  select_q   <= SRC_MDR;
                  load_q     <= '0;
                  wait_dst_q <= head_dst;
               end else begin
                  state_q  <= XF_DRIVE;
                  select_q <= head_src;
                  load_q   <= dst_onehot(head_dst);
               end
            end
            XF_WAIT: begin
               if (bus.mdr_valid) begin
                  state_q  <= XF_DRIVE;
                  select_q <= SRC_MDR;
                  load_q   <= dst_onehot(wait_dst_q);
               end
            end
            default: begin
               state_q  <= XF_IDLE;
               select_q <= IDLE_SEL;
               load_q   <= '0;
            end
         endcase
      end
   end

   assign bus.req_ready = !fifo_full;
   assign bus.Select    = select_q;
   assign bus.dst_load  = load_q;
   assign bus.err       = err_q;
   assign bus.busy      = !fifo_empty || (state_q != XF_IDLE);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

   typedef struct packed {
      logic [5:0]  sel;
      logic [23:0] load;
   } exp_t;

   logic clock;
   logic clear;
   logic rand_mode;
   logic mdr_man;
   logic mdr_rnd;

   int   n_tests;
   int   n_fail;
   int   cyc;
   logic err_exp;
   exp_t exp_q[$];
   int   load_cyc[$];

   bus_xfer_ctrl_if ifc ();

   bus_xfer_ctrl #(.DEPTH(4), .IDLE_SEL(6'd0)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (ifc.slave)
   );

   assign ifc.mdr_valid = rand_mode ? mdr_rnd : mdr_man;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc = cyc + 1;
      end
   end

   initial begin
      mdr_rnd = 1'b0;
      forever begin
         @(negedge clock);
         mdr_rnd = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: legal requests produce exactly one load, in order, of
   // Select=src and bit dst; illegal ones produce only the sticky error.
   function automatic void model_accept(input logic [5:0] s, input logic [4:0] d);
      exp_t        e;
      logic [23:0] one;
      one = 24'd1;
      if (s > 6'd23 || d > 5'd23) begin
         err_exp = 1'b1;
      end else begin
         e.sel  = s;
         e.load = one << d;
         exp_q.push_back(e);
      end
   endfunction

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [5:0] s, input logic [4:0] d, output int tries, output int acc_cyc);
      logic acc;
      acc = 1'b0;
      tries = 0;
      acc_cyc = 0;
      ifc.req_valid = 1'b1;
      ifc.req_src   = s;
      ifc.req_dst   = d;
      while (!acc && tries < 200) begin
         tries++;
         acc = ifc.req_ready;
         @(negedge clock);
      end
      ifc.req_valid = 1'b0;
      if (acc) begin
         acc_cyc = cyc - 1;
         model_accept(s, d);
      end else begin
         chk("send_accept", 32'(acc), 32'd1);
      end
   endtask

   task automatic wait_idle(input string tag);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (!ifc.busy && exp_q.size() == 0) done = 1'b1;
         else @(negedge clock);
      end
      chk({tag, "_drain"}, 32'(done), 32'd1);
   endtask

   // Monitor: every load pulse must match the head of the expected queue.
   initial begin
      exp_t e;
      logic err_hold;
      err_hold = 1'b0;
      forever begin
         @(negedge clock);
         if (clear) begin
            err_hold = 1'b0;
         end else begin
            if (ifc.dst_load != '0) begin
               load_cyc.push_back(cyc);
               chk("load_onehot", 32'($onehot(ifc.dst_load)), 32'd1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_load", 32'(ifc.dst_load), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("load_sel", 32'(ifc.Select), 32'(e.sel));
                  chk("load_vec", 32'(ifc.dst_load), 32'(e.load));
               end
            end
            if (err_hold) chk("err_sticky", 32'(ifc.err), 32'd1);
            if (ifc.err) err_hold = 1'b1;
         end
      end
   end

   initial begin
      int tries, acc_cyc;
      logic [5:0] s;
      logic [4:0] d;
      n_tests = 0;
      n_fail = 0;
      err_exp = 1'b0;
      rand_mode = 1'b0;
      mdr_man = 1'b1;
      ifc.req_valid = 1'b0;
      ifc.req_src = '0;
      ifc.req_dst = '0;
      clear = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_sel", 32'(ifc.Select), 32'd0);
      chk("rst_load", 32'(ifc.dst_load), 32'd0);
      chk("rst_err", 32'(ifc.err), 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_ready", 32'(ifc.req_ready), 32'd1);
      clear = 1'b0;
      @(negedge clock);

      // Single R5 -> Y
      load_cyc.delete();
      send(6'd5, 5'd21, tries, acc_cyc);
      chk("t1_pre_sel", 32'(ifc.Select), 32'd0);
      chk("t1_pre_load", 32'(ifc.dst_load), 32'd0);
      @(negedge clock);
      chk("t1_sel", 32'(ifc.Select), 32'd5);
      chk("t1_load", 32'(ifc.dst_load), 32'h200000);
      chk("t1_latency", 32'(cyc - acc_cyc), 32'd2);
      @(negedge clock);
      chk("t1_post_sel", 32'(ifc.Select), 32'd0);
      chk("t1_post_load", 32'(ifc.dst_load), 32'd0);
      chk("t1_post_busy", 32'(ifc.busy), 32'd0);
      chk("t1_nloads", 32'(load_cyc.size()), 32'd1);

      // Back-to-back transfers
      load_cyc.delete();
      send(6'd1, 5'd2, tries, acc_cyc);  chk("t2_ready0", 32'(tries), 32'd1);
      send(6'd2, 5'd3, tries, acc_cyc);  chk("t2_ready1", 32'(tries), 32'd1);
      send(6'd16, 5'd4, tries, acc_cyc); chk("t2_ready2", 32'(tries), 32'd1);
      send(6'd20, 5'd20, tries, acc_cyc); chk("t2_ready3", 32'(tries), 32'd1);
      wait_idle("t2");
      chk("t2_nloads", 32'(load_cyc.size()), 32'd4);
      if (load_cyc.size() == 4) chk("t2_consecutive", 32'(load_cyc[3] - load_cyc[0]), 32'd3);

      // MDR -> IR with a 3-cycle memory wait
      load_cyc.delete();
      mdr_man = 1'b0;
      send(6'd21, 5'd22, tries, acc_cyc);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t3_wait_sel", 32'(ifc.Select), 32'd21);
         chk("t3_wait_load", 32'(ifc.dst_load), 32'd0);
         chk("t3_wait_busy", 32'(ifc.busy), 32'd1);
      end
      mdr_man = 1'b1;
      @(negedge clock);
      chk("t3_load", 32'(ifc.dst_load), 32'h400000);
      chk("t3_sel", 32'(ifc.Select), 32'd21);
      wait_idle("t3");

      // Fill the FIFO behind a stalled MDR transfer
      mdr_man = 1'b0;
      send(6'd21, 5'd1, tries, acc_cyc);
      send(6'd2, 5'd3, tries, acc_cyc);
      send(6'd4, 5'd5, tries, acc_cyc);
      send(6'd6, 5'd7, tries, acc_cyc);
      send(6'd8, 5'd9, tries, acc_cyc);
      ifc.req_valid = 1'b1;
      ifc.req_src = 6'd10;
      ifc.req_dst = 5'd11;
      for (int i = 0; i < 3; i++) begin
         chk("t4_full_ready", 32'(ifc.req_ready), 32'd0);
         @(negedge clock);
      end
      ifc.req_valid = 1'b0;
      mdr_man = 1'b1;
      wait_idle("t4");

      // Illegal codes
      send(6'd30, 5'd3, tries, acc_cyc);
      wait_idle("t5a");
      chk("t5_err", 32'(ifc.err), 32'd1);
      send(6'd7, 5'd8, tries, acc_cyc);
      send(6'd3, 5'd25, tries, acc_cyc);
      send(6'd9, 5'd10, tries, acc_cyc);
      wait_idle("t5b");
      chk("t5_err_hold", 32'(ifc.err), 32'd1);

      // Clear during an MDR wait with two entries queued
      mdr_man = 1'b0;
      send(6'd21, 5'd4, tries, acc_cyc);
      send(6'd1, 5'd2, tries, acc_cyc);
      send(6'd3, 5'd4, tries, acc_cyc);
      #1;
      chk("t6_in_wait", 32'(ifc.Select), 32'd21);
      clear = 1'b1;
      exp_q.delete();
      err_exp = 1'b0;
      #1;
      chk("t6_sel", 32'(ifc.Select), 32'd0);
      chk("t6_load", 32'(ifc.dst_load), 32'd0);
      chk("t6_busy", 32'(ifc.busy), 32'd0);
      chk("t6_err", 32'(ifc.err), 32'd0);
      chk("t6_ready", 32'(ifc.req_ready), 32'd1);
      @(negedge clock);
      clear = 1'b0;
      mdr_man = 1'b1;
      load_cyc.delete();
      repeat (10) @(negedge clock);
      chk("t6_no_load", 32'(load_cyc.size()), 32'd0);
      chk("t6_idle", 32'(ifc.busy), 32'd0);

      // Randomized traffic with random memory readiness
      rand_mode = 1'b1;
      for (int k = 0; k < 80; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clock);
         if ($urandom_range(0, 4) == 0) s = 6'd21;
         else s = 6'($urandom_range(0, 25));
         d = 5'($urandom_range(0, 24));
         send(s, d, tries, acc_cyc);
      end
      rand_mode = 1'b0;
      mdr_man = 1'b1;
      wait_idle("rand");
      chk("rand_err", 32'(ifc.err), 32'(err_exp));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
